// File: rtl/mycpu_pkg.sv
// Shared types for the pipeline interlock controller.
//   mem_state_e : MEM stage occupancy/wait state
//   slot_t      : one in-flight register writer {valid, we, waddr, is_load}
//   REG_ZERO    : hard-wired zero register, never a hazard source
package mycpu_pkg;

    typedef enum logic [1:0] {
        M_EMPTY = 2'd0,
        M_BUSY  = 2'd1,
        M_WAIT  = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] waddr;
        logic       is_load;
    } slot_t;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam slot_t      SLOT_EMPTY = '0;

endpackage

// File: rtl/hz_src_match.sv
// Compares one ID source register against one in-flight writer slot.
//   src      : source register number
//   src_used : the instruction actually reads this source
//   slot     : in-flight writer (EXE or MEM)
//   match    : source depends on the slot's pending write
module hz_src_match
    import mycpu_pkg::*;
(
    input  logic [4:0] src,
    input  logic       src_used,
    input  slot_t      slot,
    output logic       match
);

    always_comb begin
        match = src_used & (src != REG_ZERO) & slot.valid & slot.we
              & (slot.waddr == src);
    end

endmodule

// File: rtl/load_use_ctrl.sv
// Pipeline interlock controller: tracks the EXE and MEM register writers,
// stalls ID on load-use hazards that forwarding cannot cover, sequences the
// MEM wait for data-SRAM read data and produces the EXE/MEM allow-in signals.
//   clk, resetn          : clock, synchronous active-low reset
//   ds_*                 : ID-stage instruction fields
//   br_taken_cancel      : raw branch decision from ID
//   data_sram_data_ok    : one-cycle load data return pulse
//   ds_stall             : hold ID
//   es_allow_in          : EXE may accept
//   ms_allow_in          : MEM may accept
//   br_cancel_ok         : branch decision taken from valid operands
//   mem_err              : sticky load timeout
//   stall_cnt            : saturating count of ds_stall cycles
module load_use_ctrl
    import mycpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 32
)
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             ds_valid,
    input  logic [4:0]       ds_rs1,
    input  logic [4:0]       ds_rs2,
    input  logic             ds_rs1_used,
    input  logic             ds_rs2_used,
    input  logic             ds_rf_we,
    input  logic [4:0]       ds_rf_waddr,
    input  logic             ds_is_load,
    input  logic             br_taken_cancel,
    input  logic             data_sram_data_ok,
    output logic             ds_stall,
    output logic             es_allow_in,
    output logic             ms_allow_in,
    output logic             br_cancel_ok,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    slot_t             es_q, es_d;
    slot_t             ms_q, ms_d;
    mem_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic  m_wait, ms_ready, ds_fire, es_to_ms;
    logic  es_hit1, es_hit2, ms_hit1, ms_hit2;
    slot_t ds_slot;

    hz_src_match u_es_rs1 (.src(ds_rs1), .src_used(ds_rs1_used), .slot(es_q), .match(es_hit1));
    hz_src_match u_es_rs2 (.src(ds_rs2), .src_used(ds_rs2_used), .slot(es_q), .match(es_hit2));
    hz_src_match u_ms_rs1 (.src(ds_rs1), .src_used(ds_rs1_used), .slot(ms_q), .match(ms_hit1));
    hz_src_match u_ms_rs2 (.src(ds_rs2), .src_used(ds_rs2_used), .slot(ms_q), .match(ms_hit2));

    always_comb begin
        m_wait      = (state_q == M_WAIT);
        ms_ready    = (state_q == M_BUSY) | (m_wait & data_sram_data_ok);
        ms_allow_in = (state_q == M_EMPTY) | ms_ready;
        es_allow_in = ~es_q.valid | ms_allow_in;
        // A load in EXE always stalls a consumer; a load in MEM only until
        // its data returns, after which forwarding from MEM covers it.
        ds_stall    = ds_valid & (((es_hit1 | es_hit2) & es_q.is_load)
                    | ((ms_hit1 | ms_hit2) & ms_q.is_load & m_wait & ~data_sram_data_ok));
        br_cancel_ok = br_taken_cancel & ~ds_stall;
        ds_fire     = ds_valid & ~ds_stall & es_allow_in;
        es_to_ms    = es_q.valid & ms_allow_in;

        ds_slot.valid   = 1'b1;
        ds_slot.we      = ds_rf_we;
        ds_slot.waddr   = ds_rf_waddr;
        ds_slot.is_load = ds_is_load;
    end

    always_comb begin
        es_d        = es_q;
        ms_d        = ms_q;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;

        if (ds_fire) begin
            es_d = ds_slot;
        end else if (es_to_ms) begin
            es_d.valid = 1'b0;
        end

        if (es_to_ms) begin
            ms_d    = es_q;
            state_d = es_q.is_load ? M_WAIT : M_BUSY;
        end else if (ms_ready) begin
            ms_d.valid = 1'b0;
            state_d    = M_EMPTY;
        end

        // Counter holds at TIMEOUT so it cannot wrap during a long wait.
        if (es_to_ms && es_q.is_load) begin
            wait_cnt_d = '0;
        end else if (m_wait && (wait_cnt_q != WAIT_W'(TIMEOUT))) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        if (m_wait && !data_sram_data_ok && (wait_cnt_q == WAIT_W'(TIMEOUT - 1))) begin
            mem_err_d = 1'b1;
        end

        if (ds_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            es_q        <= SLOT_EMPTY;
            ms_q        <= SLOT_EMPTY;
            state_q     <= M_EMPTY;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            es_q        <= es_d;
            ms_q        <= ms_d;
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_load_use_ctrl.sv
// Directed-vector bench for load_use_ctrl. Stimulus pushes hand-computed
// expected outputs per cycle into a queue; a monitor pops and compares.
// The stall counter is narrowed to 2 bits so saturation is reachable.
module tb_load_use_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ds_valid = 1'b0;
    logic [4:0] ds_rs1 = '0, ds_rs2 = '0, ds_rf_waddr = '0;
    logic       ds_rs1_used = 1'b0, ds_rs2_used = 1'b0, ds_rf_we = 1'b0, ds_is_load = 1'b0;
    logic       br_taken_cancel = 1'b0, data_sram_data_ok = 1'b0;
    logic       ds_stall, es_allow_in, ms_allow_in, br_cancel_ok, mem_err;
    logic [1:0] stall_cnt;

    always #5 clk = ~clk;

    load_use_ctrl #(.TIMEOUT(256), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .ds_valid(ds_valid), .ds_rs1(ds_rs1), .ds_rs2(ds_rs2),
        .ds_rs1_used(ds_rs1_used), .ds_rs2_used(ds_rs2_used),
        .ds_rf_we(ds_rf_we), .ds_rf_waddr(ds_rf_waddr), .ds_is_load(ds_is_load),
        .br_taken_cancel(br_taken_cancel), .data_sram_data_ok(data_sram_data_ok),
        .ds_stall(ds_stall), .es_allow_in(es_allow_in), .ms_allow_in(ms_allow_in),
        .br_cancel_ok(br_cancel_ok), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2, we;
        logic [4:0] wa;
        logic       ld;
    } ins_t;

    typedef struct {
        string      name;
        logic       st, esa, msa, bco, err;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    localparam ins_t NOP = '0;

    function automatic ins_t LD(input logic [4:0] wa, input logic [4:0] base);
        return '{v:1'b1, rs1:base, rs2:5'd0, u1:1'b1, u2:1'b0, we:1'b1, wa:wa, ld:1'b1};
    endfunction

    function automatic ins_t OP(input logic [4:0] wa, input logic [4:0] a, input logic [4:0] b);
        return '{v:1'b1, rs1:a, rs2:b, u1:1'b1, u2:1'b1, we:1'b1, wa:wa, ld:1'b0};
    endfunction

    // Immediate form: rs2 field carries garbage and is not read.
    function automatic ins_t OPI(input logic [4:0] wa, input logic [4:0] a, input logic [4:0] junk);
        return '{v:1'b1, rs1:a, rs2:junk, u1:1'b1, u2:1'b0, we:1'b1, wa:wa, ld:1'b0};
    endfunction

    function automatic ins_t BEQ(input logic [4:0] a, input logic [4:0] b);
        return '{v:1'b1, rs1:a, rs2:b, u1:1'b1, u2:1'b1, we:1'b0, wa:5'd0, ld:1'b0};
    endfunction

    task automatic drive(input ins_t i, input logic br, input logic dok);
        ds_valid          = i.v;
        ds_rs1            = i.rs1;
        ds_rs2            = i.rs2;
        ds_rs1_used       = i.u1;
        ds_rs2_used       = i.u2;
        ds_rf_we          = i.we;
        ds_rf_waddr       = i.wa;
        ds_is_load        = i.ld;
        br_taken_cancel   = br;
        data_sram_data_ok = dok;
    endtask

    task automatic cyc(input ins_t i, input logic br, input logic dok,
                       input logic st, input logic esa, input logic msa,
                       input logic bco, input logic err, input int cnt,
                       input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(i, br, dok);
        e.name = nm; e.st = st; e.esa = esa; e.msa = msa;
        e.bco = bco; e.err = err; e.cnt = cnt[1:0];
        exp_q.push_back(e);
    endtask

    task automatic rst(input logic dok);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        drive(NOP, 1'b0, dok);
    endtask

    task automatic chk(input string nm, input string fld, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #4;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.name, "ds_stall",     {1'b0, ds_stall},     {1'b0, e.st});
                chk(e.name, "es_allow_in",  {1'b0, es_allow_in},  {1'b0, e.esa});
                chk(e.name, "ms_allow_in",  {1'b0, ms_allow_in},  {1'b0, e.msa});
                chk(e.name, "br_cancel_ok", {1'b0, br_cancel_ok}, {1'b0, e.bco});
                chk(e.name, "mem_err",      {1'b0, mem_err},      {1'b0, e.err});
                chk(e.name, "stall_cnt",    stall_cnt,            e.cnt);
            end
        end
    end

    initial begin : stimulus
        int drain;

        // T1: ld r4 ; add r5,r4,r6 ; data_ok in first MEM cycle -> 1 stall
        rst(1'b0);
        cyc(NOP,          0, 0, 0, 1, 1, 0, 0, 0, "t1_reset");
        cyc(LD(4, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t1_ld");
        cyc(OP(5, 4, 6),  0, 0, 1, 1, 1, 0, 0, 0, "t1_stall");
        cyc(OP(5, 4, 6),  0, 1, 0, 1, 1, 0, 0, 1, "t1_release");
        cyc(NOP,          0, 0, 0, 1, 1, 0, 0, 1, "t1_after");

        // T2: consumer on rs2, data_ok in third MEM cycle -> 3 stalls
        rst(1'b0);
        cyc(LD(4, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t2_ld");
        cyc(OP(5, 6, 4),  0, 0, 1, 1, 1, 0, 0, 0, "t2_stall_exe");
        cyc(OP(5, 6, 4),  0, 0, 1, 1, 0, 0, 0, 1, "t2_stall_mem1");
        cyc(OP(5, 6, 4),  0, 0, 1, 1, 0, 0, 0, 2, "t2_stall_mem2");
        cyc(OP(5, 6, 4),  0, 1, 0, 1, 1, 0, 0, 3, "t2_release");
        cyc(NOP,          0, 0, 0, 1, 1, 0, 0, 3, "t2_after");

        // T3: one instruction between, late data_ok -> EXE full, es_allow_in low
        rst(1'b0);
        cyc(LD(4, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t3_ld");
        cyc(OP(7, 1, 2),  0, 0, 0, 1, 1, 0, 0, 0, "t3_indep");
        cyc(OP(5, 4, 6),  0, 0, 1, 0, 0, 0, 0, 0, "t3_full1");
        cyc(OP(5, 4, 6),  0, 0, 1, 0, 0, 0, 0, 1, "t3_full2");
        cyc(OP(5, 4, 6),  0, 1, 0, 1, 1, 0, 0, 2, "t3_release");
        cyc(NOP,          0, 0, 0, 1, 1, 0, 0, 2, "t3_busy");

        // T4: one instruction between, data_ok in first MEM cycle -> no stall
        rst(1'b0);
        cyc(LD(4, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t4_ld");
        cyc(OP(7, 1, 2),  0, 0, 0, 1, 1, 0, 0, 0, "t4_indep");
        cyc(OP(5, 4, 6),  0, 1, 0, 1, 1, 0, 0, 0, "t4_nostall");

        // T5: ld r0 then r0 readers; non-load producer is forwarded, not stalled
        rst(1'b0);
        cyc(LD(0, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t5_ld_r0");
        cyc(OP(8, 0, 0),  0, 0, 0, 1, 1, 0, 0, 0, "t5_read_r0");
        cyc(OP(9, 8, 3),  0, 0, 0, 0, 0, 0, 0, 0, "t5_fwd_wait");
        cyc(OP(9, 8, 3),  0, 1, 0, 1, 1, 0, 0, 0, "t5_fwd_go");

        // T6: unused rs2 naming the load destination never stalls
        rst(1'b0);
        cyc(LD(4, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t6_ld");
        cyc(OPI(5, 1, 4), 0, 0, 0, 1, 1, 0, 0, 0, "t6_unused");
        cyc(NOP,          0, 1, 0, 1, 1, 0, 0, 0, "t6_drain");

        // T7: beq on load destination in EXE -> br_cancel_ok held low while stalled
        rst(1'b0);
        cyc(LD(4, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t7_ld");
        cyc(BEQ(4, 9),    1, 0, 1, 1, 1, 0, 0, 0, "t7_br_stall");
        cyc(BEQ(4, 9),    1, 1, 0, 1, 1, 1, 0, 1, "t7_br_ok");

        // T8: stall counter saturates at all-ones
        rst(1'b0);
        cyc(LD(4, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t8_ld");
        cyc(OP(5, 4, 6),  0, 0, 1, 1, 1, 0, 0, 0, "t8_s1");
        cyc(OP(5, 4, 6),  0, 0, 1, 1, 0, 0, 0, 1, "t8_s2");
        cyc(OP(5, 4, 6),  0, 0, 1, 1, 0, 0, 0, 2, "t8_s3");
        cyc(OP(5, 4, 6),  0, 0, 1, 1, 0, 0, 0, 3, "t8_s4");
        cyc(OP(5, 4, 6),  0, 0, 1, 1, 0, 0, 0, 3, "t8_s5_sat");
        cyc(OP(5, 4, 6),  0, 1, 0, 1, 1, 0, 0, 3, "t8_release");

        // T9: 256 M_WAIT cycles without data_ok -> mem_err, sticky after release
        rst(1'b0);
        cyc(LD(4, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t9_ld");
        cyc(NOP,          0, 0, 0, 1, 1, 0, 0, 0, "t9_to_mem");
        for (int k = 1; k <= 256; k++) begin
            cyc(NOP,      0, 0, 0, 1, 0, 0, 0, 0, "t9_wait");
        end
        cyc(OP(5, 4, 6),  0, 0, 1, 1, 0, 0, 1, 0, "t9_err_set");
        cyc(OP(5, 4, 6),  0, 1, 0, 1, 1, 0, 1, 1, "t9_release");
        cyc(NOP,          0, 0, 0, 1, 1, 0, 1, 1, "t9_sticky");

        // T10: reset while in M_WAIT, data_ok afterwards is ignored
        rst(1'b0);
        cyc(LD(4, 1),     0, 0, 0, 1, 1, 0, 0, 0, "t10_ld");
        cyc(NOP,          0, 0, 0, 1, 1, 0, 0, 0, "t10_to_mem");
        cyc(NOP,          0, 0, 0, 1, 0, 0, 0, 0, "t10_wait");
        rst(1'b1);
        cyc(NOP,          0, 1, 0, 1, 1, 0, 0, 0, "t10_dok_ignored");
        cyc(OP(5, 4, 6),  0, 0, 0, 1, 1, 0, 0, 0, "t10_no_slot");
        cyc(NOP,          0, 0, 0, 1, 1, 0, 0, 0, "t10_idle");

        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        #6;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
